// File: rtl/fft_bfly_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fft_bfly_sequencer                                            |
// | Purpose  : Walks one shared radix-2 butterfly over an in-place FFT held  |
// |            in an external dual-port sample RAM. For every butterfly it   |
// |            reads both operands (RD), captures them into the butterfly    |
// |            operand registers (CAP) and writes both results back to the   |
// |            same two addresses (WR). Three cycles per butterfly.          |
// | Options  : FFT_SEQ_SINGLE_STEP_EN adds step_mode/step inputs and a HOLD  |
// |            state that parks the sequencer after every write until step.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fft_bfly_sequencer #(
  parameter int N_LOG2 = 5,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
`ifdef FFT_SEQ_SINGLE_STEP_EN
  input  logic                  step_mode,
  input  logic                  step,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [N_LOG2-1:0]     rd_addr_a,
  output logic [N_LOG2-1:0]     rd_addr_b,
  input  logic [2*DATA_W-1:0]   rd_data_a,
  input  logic [2*DATA_W-1:0]   rd_data_b,
  output logic                  wr_en,
  output logic [N_LOG2-1:0]     wr_addr_a,
  output logic [N_LOG2-1:0]     wr_addr_b,
  output logic [2*DATA_W-1:0]   wr_data_a,
  output logic [2*DATA_W-1:0]   wr_data_b,
  output logic [DATA_W-1:0]     bf_xir,
  output logic [DATA_W-1:0]     bf_xic,
  output logic [DATA_W-1:0]     bf_xjr,
  output logic [DATA_W-1:0]     bf_xjc,
  output logic [2:0]            bf_stage,
  output logic [N_LOG2-1:0]     bf_i,
  output logic [N_LOG2-1:0]     bf_j,
  input  logic [DATA_W-1:0]     bf_yir,
  input  logic [DATA_W-1:0]     bf_yic,
  input  logic [DATA_W-1:0]     bf_yjr,
  input  logic [DATA_W-1:0]     bf_yjc
);

  // Butterflies per stage, and the counter values of the very last butterfly
  localparam int unsigned       C_HALF_N = (1 << N_LOG2) / 2;
  localparam logic [2:0]        C_S_LAST = 3'(N_LOG2 - 1);
  localparam logic [N_LOG2-1:0] C_K_LAST = N_LOG2'(C_HALF_N - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3
`ifdef FFT_SEQ_SINGLE_STEP_EN
    ,
    ST_HOLD = 3'd4
`endif
  } state_t;

  state_t                state_q;
  logic [2:0]            s_q;
  logic [N_LOG2-1:0]     k_q;
  logic [2:0]            s_d;
  logic [N_LOG2-1:0]     k_d;

  logic                  busy_q;
  logic                  done_q;
  logic                  wr_en_q;
  logic [N_LOG2-1:0]     rd_addr_a_q;
  logic [N_LOG2-1:0]     rd_addr_b_q;
  logic [N_LOG2-1:0]     wr_addr_a_q;
  logic [N_LOG2-1:0]     wr_addr_b_q;
  logic [DATA_W-1:0]     bf_xir_q;
  logic [DATA_W-1:0]     bf_xic_q;
  logic [DATA_W-1:0]     bf_xjr_q;
  logic [DATA_W-1:0]     bf_xjc_q;
  logic [2:0]            bf_stage_q;
  logic [N_LOG2-1:0]     bf_i_q;
  logic [N_LOG2-1:0]     bf_j_q;

  logic                  w_last;
  logic                  w_step_mode;
  logic                  w_advance;
  logic [N_LOG2-1:0]     w_i_cur;
  logic [N_LOG2-1:0]     w_j_cur;
  logic [N_LOG2-1:0]     w_i_nxt;
  logic [N_LOG2-1:0]     w_j_nxt;

  // Distance between the two butterfly legs in stage s
  function automatic logic [N_LOG2-1:0] f_half(input logic [2:0] s);
    return N_LOG2'(1) << s;
  endfunction

  // Index i: insert a zero at bit position s of k (upper bits shift up by one)
  function automatic logic [N_LOG2-1:0] f_idx_i(input logic [2:0]        s,
                                                input logic [N_LOG2-1:0] k);
    logic [3:0] s_plus1;
    s_plus1 = {1'b0, s} + 4'd1;
    return ((k >> s) << s_plus1) | (k & (f_half(s) - N_LOG2'(1)));
  endfunction

  assign w_last  = (s_q == C_S_LAST) && (k_q == C_K_LAST);
  assign w_i_cur = f_idx_i(s_q, k_q);
  assign w_j_cur = w_i_cur + f_half(s_q);
  assign w_i_nxt = f_idx_i(s_d, k_d);
  assign w_j_nxt = w_i_nxt + f_half(s_d);

`ifdef FFT_SEQ_SINGLE_STEP_EN
  assign w_step_mode = step_mode;
  assign w_advance   = ((state_q == ST_WR) && !step_mode) ||
                       ((state_q == ST_HOLD) && step);
`else
  assign w_step_mode = 1'b0;
  assign w_advance   = (state_q == ST_WR);
`endif

  // Next (stage, butterfly) pair; wraps to (0,0) after the final butterfly
  always_comb begin
    s_d = s_q;
    k_d = k_q + N_LOG2'(1);
    if (k_q == C_K_LAST) begin
      k_d = '0;
      s_d = w_last ? 3'd0 : s_q + 3'd1;
    end
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      wr_addr_a_q <= '0;
      wr_addr_b_q <= '0;
      bf_xir_q    <= '0;
      bf_xic_q    <= '0;
      bf_xjr_q    <= '0;
      bf_xjc_q    <= '0;
      bf_stage_q  <= '0;
      bf_i_q      <= '0;
      bf_j_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Counters are (0,0) here, so the current indices are butterfly 0
          if (start) begin
            state_q     <= ST_RD;
            busy_q      <= 1'b1;
            rd_addr_a_q <= w_i_cur;
            rd_addr_b_q <= w_j_cur;
          end
        end
        ST_RD: begin
          state_q <= ST_CAP;
        end
        ST_CAP: begin
          bf_xir_q    <= rd_data_a[2*DATA_W-1:DATA_W];
          bf_xic_q    <= rd_data_a[DATA_W-1:0];
          bf_xjr_q    <= rd_data_b[2*DATA_W-1:DATA_W];
          bf_xjc_q    <= rd_data_b[DATA_W-1:0];
          bf_stage_q  <= s_q;
          bf_i_q      <= w_i_cur;
          bf_j_q      <= w_j_cur;
          wr_addr_a_q <= w_i_cur;
          wr_addr_b_q <= w_j_cur;
          wr_en_q     <= 1'b1;
          state_q     <= ST_WR;
        end
        ST_WR: begin
          wr_en_q <= 1'b0;
`ifdef FFT_SEQ_SINGLE_STEP_EN
          if (w_step_mode) begin
            state_q <= ST_HOLD;
          end
`endif
        end
`ifdef FFT_SEQ_SINGLE_STEP_EN
        ST_HOLD: begin
          state_q <= ST_HOLD;
        end
`endif
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // Leaving a butterfly: step the counters and either finish or read next
      if (w_advance) begin
        s_q <= s_d;
        k_q <= k_d;
        if (w_last) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q     <= ST_RD;
          rd_addr_a_q <= w_i_nxt;
          rd_addr_b_q <= w_j_nxt;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_en     = wr_en_q;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign wr_addr_a = wr_addr_a_q;
  assign wr_addr_b = wr_addr_b_q;
  assign bf_xir    = bf_xir_q;
  assign bf_xic    = bf_xic_q;
  assign bf_xjr    = bf_xjr_q;
  assign bf_xjc    = bf_xjc_q;
  assign bf_stage  = bf_stage_q;
  assign bf_i      = bf_i_q;
  assign bf_j      = bf_j_q;

  // Write data comes straight from the combinational butterfly; gated so the
  // data ports read zero whenever no write is in flight (including reset)
  assign wr_data_a = wr_en_q ? {bf_yir, bf_yic} : '0;
  assign wr_data_b = wr_en_q ? {bf_yjr, bf_yjc} : '0;

endmodule
`default_nettype wire

// File: tb/tb_fft_bfly_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fft_bfly_sequencer                                         |
// | Purpose  : Self-checking bench for fft_bfly_sequencer with a RAM model,  |
// |            a behavioural butterfly and a reference in-place FFT walker.  |
// | Options  : FFT_SEQ_SINGLE_STEP_EN also exercises single-step mode.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fft_bfly_sequencer;

  localparam int N_LOG2 = 5;
  localparam int DATA_W = 16;
  localparam int N      = 32;

  typedef struct packed {
    logic [2:0]  st;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] da;
    logic [31:0] db;
  } wrec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
`ifdef FFT_SEQ_SINGLE_STEP_EN
  logic step_mode = 1'b0;
  logic step = 1'b0;
`endif
  logic        busy, done, wr_en;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, bf_i, bf_j;
  logic [31:0] rd_data_a, rd_data_b, wr_data_a, wr_data_b;
  logic [15:0] bf_xir, bf_xic, bf_xjr, bf_xjc;
  logic [15:0] bf_yir, bf_yic, bf_yjr, bf_yjc;
  logic [2:0]  bf_stage;

  logic bf_mix = 1'b0;

  always #5 clk = ~clk;

  fft_bfly_sequencer #(.N_LOG2(N_LOG2), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef FFT_SEQ_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .busy(busy), .done(done),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .bf_xir(bf_xir), .bf_xic(bf_xic), .bf_xjr(bf_xjr), .bf_xjc(bf_xjc),
    .bf_stage(bf_stage), .bf_i(bf_i), .bf_j(bf_j),
    .bf_yir(bf_yir), .bf_yic(bf_yic), .bf_yjr(bf_yjr), .bf_yjc(bf_yjc)
  );

  // Behavioural butterfly: pass-through, or a simple mixing function
  assign bf_yir = bf_mix ? bf_xir + bf_xjr : bf_xir;
  assign bf_yic = bf_mix ? bf_xic + bf_xjc : bf_xic;
  assign bf_yjr = bf_mix ? bf_xir ^ bf_xjr : bf_xjr;
  assign bf_yjc = bf_mix ? bf_xic - bf_xjc : bf_xjc;

  // Sample RAM: one-cycle read latency, writes land at the clock edge
  logic [31:0] mem [N];
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = 5'd0;
  logic [31:0] load_data = 32'd0;

  always @(posedge clk) begin
    rd_data_a <= mem[rd_addr_a];
    rd_data_b <= mem[rd_addr_b];
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (wr_en) begin
      mem[wr_addr_a] <= wr_data_a;
      mem[wr_addr_b] <= wr_data_b;
    end
  end

  // Activity monitor, sampled on the falling edge
  logic  mon_clear = 1'b0;
  int    cyc, busy_cnt, wr_cnt, done_cnt, first_busy, done_cyc, act_n;
  wrec_t act_arr [256];

  always @(negedge clk) begin
    if (mon_clear) begin
      cyc <= 0; busy_cnt <= 0; wr_cnt <= 0; done_cnt <= 0;
      first_busy <= -1; done_cyc <= -1; act_n <= 0;
    end else begin
      cyc <= cyc + 1;
      if (busy) begin
        busy_cnt <= busy_cnt + 1;
        if (first_busy < 0) first_busy <= cyc + 1;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        if (done_cyc < 0) done_cyc <= cyc + 1;
      end
      if (wr_en) begin
        wr_cnt <= wr_cnt + 1;
        act_arr[8'(act_n)] <= '{bf_stage, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b};
        act_n <= act_n + 1;
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [N];
  wrec_t       exp_q [$];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic void bf_model(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] ya, output logic [31:0] yb);
    logic [15:0] ar, ai, br, bi;
    {ar, ai} = a;
    {br, bi} = b;
    if (bf_mix) begin
      ya = {ar + br, ai + bi};
      yb = {ar ^ br, ai - bi};
    end else begin
      ya = a;
      yb = b;
    end
  endfunction

  task automatic snapshot();
    for (int i = 0; i < N; i++) ref_mem[5'(i)] = mem[5'(i)];
    exp_q.delete();
  endtask

  // Whole in-place FFT: in each stage pair every index with bit s clear
  // against its partner with bit s set, in increasing order of the lower index
  task automatic model_fft();
    logic [31:0] ya, yb;
    for (int s = 0; s < N_LOG2; s++) begin
      for (int i = 0; i < N; i++) begin
        if ((i & (1 << s)) == 0) begin
          int j;
          j = i + (1 << s);
          bf_model(ref_mem[5'(i)], ref_mem[5'(j)], ya, yb);
          exp_q.push_back('{3'(s), 5'(i), 5'(j), ya, yb});
          ref_mem[5'(i)] = ya;
          ref_mem[5'(j)] = yb;
        end
      end
    end
  endtask

  task automatic clear_mon();
    mon_clear = 1'b1;
    tick();
    mon_clear = 1'b0;
  endtask

  task automatic compare_trace();
    chk("trace_len", 128'(act_n), 128'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < act_n; k++)
      chk($sformatf("write[%0d]", k), 128'(act_arr[8'(k)]), 128'(exp_q[k]));
    for (int i = 0; i < N; i++)
      chk($sformatf("ram[%0d]", i), 128'(mem[5'(i)]), 128'(ref_mem[5'(i)]));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, 128'({busy, done, wr_en, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b,
                              bf_stage, bf_i, bf_j, wr_data_a, wr_data_b}), 128'(0));
    chk({tag, "_bfx"}, 128'({bf_xir, bf_xic, bf_xjr, bf_xjc}), 128'(0));
  endtask

  // One or more FFT runs from the current RAM contents, checked end to end
  task automatic run_fft(input bit pulse_mid, input bit hold_start, input int n_runs);
    snapshot();
    for (int r = 0; r < n_runs; r++) model_fft();
    clear_mon();
    start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    for (int t = 0; t < 3000 && done_cnt < n_runs; t++) begin
      if (pulse_mid) start = (t >= 50 && t < 53);
      if (hold_start && done_cnt >= 1 && start) begin
        chk("restart_busy_after_done", 128'(busy), 128'(1));
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("done_seen", 128'(done_cnt), 128'(n_runs));
    repeat (4) tick();
    chk("busy_cycles", 128'(busy_cnt), 128'(240 * n_runs));
    chk("wr_cycles", 128'(wr_cnt), 128'(80 * n_runs));
    chk("done_pulses", 128'(done_cnt), 128'(n_runs));
    chk("done_latency", 128'(done_cyc - first_busy), 128'(240));
    chk("idle_after_run", 128'({busy, done, wr_en}), 128'(0));
    compare_trace();
  endtask

  initial begin
    // Asynchronous reset between clock edges
    #3 rst_n = 1'b0;
    #1 check_zero("reset_async");
    for (int i = 0; i < N; i++) begin
      load_en = 1'b1;
      load_addr = 5'(i);
      load_data = $urandom;
      tick();
    end
    load_en = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
    check_zero("reset_idle");

    // Pass-through butterfly: RAM unchanged, address trace checked in detail
    bf_mix = 1'b0;
    run_fft(1'b0, 1'b0, 1);
    for (int k = 0; k < 16; k++)
      chk($sformatf("s0_pair[%0d]", k), 128'({act_arr[8'(k)].a, act_arr[8'(k)].b}),
          128'({5'(2 * k), 5'(2 * k + 1)}));
    chk("s2_k5", 128'({act_arr[8'd37].st, act_arr[8'd37].a, act_arr[8'd37].b}),
        128'({3'd2, 5'd9, 5'd13}));
    chk("s4_k15", 128'({act_arr[8'd79].st, act_arr[8'd79].a, act_arr[8'd79].b}),
        128'({3'd4, 5'd15, 5'd31}));
    for (int s = 0; s < N_LOG2; s++) begin
      int cnt [N];
      bit ok;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int k = 0; k < act_n; k++) begin
        if (int'(act_arr[8'(k)].st) == s) begin
          cnt[act_arr[8'(k)].a]++;
          cnt[act_arr[8'(k)].b]++;
        end
      end
      ok = 1'b1;
      for (int i = 0; i < N; i++) if (cnt[i] != 1) ok = 1'b0;
      chk($sformatf("stage%0d_cover", s), 128'(ok), 128'(1));
    end

    // Mixing butterfly with start pulses during busy (ignored)
    bf_mix = 1'b1;
    run_fft(1'b1, 1'b0, 1);

    // start held high: back-to-back runs
    run_fft(1'b0, 1'b1, 2);

    // Reset during stage 2, then a fresh complete run
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 500 && !(bf_stage == 3'd2 && wr_en); t++) tick();
    chk("reached_stage2", 128'({bf_stage, wr_en}), 128'({3'd2, 1'b1}));
    #1 rst_n = 1'b0;
    #1 check_zero("reset_mid_run");
    repeat (2) tick();
    rst_n = 1'b1;
    clear_mon();
    repeat (20) tick();
    chk("no_write_after_reset", 128'(wr_cnt), 128'(0));
    chk("no_busy_after_reset", 128'(busy_cnt), 128'(0));
    run_fft(1'b0, 1'b0, 1);

`ifdef FFT_SEQ_SINGLE_STEP_EN
    // Single-step: one write per step pulse, done after the 80th step
    snapshot();
    model_fft();
    clear_mon();
    step_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("step_first_wr", 128'(wr_cnt), 128'(1));
    chk("step_hold_busy", 128'(busy), 128'(1));
    for (int n = 2; n <= 80; n++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (6) tick();
      chk($sformatf("step_wr[%0d]", n), 128'(wr_cnt), 128'(n));
    end
    chk("step_no_done_yet", 128'({done_cnt, busy}), 128'({32'd0, 1'b1}));
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (3) tick();
    chk("step_done", 128'(done_cnt), 128'(1));
    chk("step_idle", 128'(busy), 128'(0));
    compare_trace();
    step_mode = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_bfly_sequencer.md
Name: fft_bfly_sequencer

Overview:
- Sequences one shared radix-2 `butterfly` unit over a complete in-place FFT held in an external sample RAM.
- Generates the `stage`, `i`, `j` operand indices for every butterfly and reads both operands from the RAM.
- Presents the operands to the butterfly, then writes both results back to the same two addresses.
- Sits between the top-level control (start/done) and the RAM + butterfly pair. Replaces the bench-driven single-shot use of the butterfly.

Parameters:
- N_LOG2, 5, log2 of FFT length. Number of stages = N_LOG2; points N = 2**N_LOG2; legal range 1..8.
- DATA_W, 16, width of one real or imaginary word (sign-magnitude: bit DATA_W-1 = sign). Passed through uninterpreted.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset is asynchronous and active-low.
- start  in  1  begin an FFT; sampled only in IDLE.
- busy  out  1  high while an FFT is in progress.
- done  out  1  one-cycle pulse when the final write completes.
- rd_addr_a  out  N_LOG2  RAM read port A address (index i).
- rd_addr_b  out  N_LOG2  RAM read port B address (index j).
- rd_data_a  in  2*DATA_W  {real, imag} from port A, valid one cycle after address.
- rd_data_b  in  2*DATA_W  {real, imag} from port B, same latency.
- wr_en  out  1  write strobe for both write ports.
- wr_addr_a  out  N_LOG2  write address A.
- wr_addr_b  out  N_LOG2  write address B.
- wr_data_a  out  2*DATA_W  {yir, yic}.
- wr_data_b  out  2*DATA_W  {yjr, yjc}.
- bf_xir, bf_xic, bf_xjr, bf_xjc  out  DATA_W each  butterfly operands (registered).
- bf_stage  out  3  current stage.
- bf_i  out  N_LOG2  current index i.
- bf_j  out  N_LOG2  current index j.
- bf_yir, bf_yic, bf_yjr, bf_yjc  in  DATA_W each  butterfly results; combinational from bf_x*.

Behaviour:
- Reset (async, rst_n=0): state IDLE, stage counter s=0, butterfly counter k=0. Every output is 0: busy, done, wr_en, all addresses, all bf_* outputs.
- FSM states: IDLE -> RD -> CAP -> WR -> RD (next butterfly) or IDLE (after the last butterfly).
  - IDLE: busy=0. If start=1, go to RD and set busy=1 from the next cycle. start in any other state is ignored.
  - RD: drive rd_addr_a=i, rd_addr_b=j.
  - CAP: rd_data valid. On the clock edge, register the data into bf_x* ({real,imag} split) and register bf_stage=s, bf_i=i, bf_j=j.
  - WR: wr_en=1, wr_addr_a=i, wr_addr_b=j, wr_data_a={bf_yir,bf_yic}, wr_data_b={bf_yjr,bf_yjc}. bf_x* are held stable throughout WR.
- Index generation for stage s and butterfly k (0..N/2-1):
  - half = 1<<s
  - i = ((k>>s)<<(s+1)) | (k & (half-1))
  - j = i + half
  - All arithmetic is in N_LOG2 bits; no overflow is possible by construction.
- Advance on leaving WR:
  - If k < N/2-1: k++.
  - Else k=0 and s++.
  - If s = N_LOG2-1 and k = N/2-1: go to IDLE and pulse done for exactly one cycle (the first IDLE cycle). busy falls in that same cycle.
- Latency:
  - 3 cycles per butterfly.
  - busy high for 3*N_LOG2*N/2 cycles (240 at the defaults).
  - done in the cycle after the last WR.
- Hazards:
  - Writes land at the WR edge. The next read is issued one cycle later, so a stage boundary needs no bubble.
  - The RAM must return written data on a read issued in the cycle after the write.
- start asserted in the same cycle as done: accepted, and a new FFT begins; done still pulses.
- start held high continuously: back-to-back FFTs with one IDLE cycle between them.
- Reset mid-operation: immediate return to the reset state, wr_en deasserts asynchronously, and no further writes occur. The RAM contents are left partially transformed.
- Addresses and bf_* hold their last values in IDLE; they are not cleared except by reset.

Optional Feature:
- Macro: FFT_SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input `step_mode` (1 bit) and input `step` (1 bit).
  - With step_mode=1, the FSM enters a HOLD state after each WR, with busy still high.
  - It proceeds (to RD or IDLE/done) only on a cycle with step=1. Each step advances exactly one butterfly.
  - With step_mode=0, behaviour is identical to the base block.
- When undefined: no ports, no HOLD state, and timing exactly as in Behaviour.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> busy=0, done=0, wr_en=0, all addresses 0, bf_* 0 without waiting for an edge.
- Defaults, one start pulse -> busy high exactly 240 cycles, exactly 80 wr_en cycles, done pulses once at cycle 241, then IDLE.
- Address trace:
  - Stage 0 pairs in order are (0,1),(2,3)...(30,31).
  - Stage 2, k=5 -> i=9, j=13, bf_stage=2.
  - Stage 4, k=15 -> i=15, j=31.
  - Every index 0..31 is written exactly once per stage.
- Data path: RAM model with a pass-through butterfly model (y=x) and known contents -> RAM is unchanged after done, and wr_data matches rd_data from two cycles earlier on every write.
- Handshake:
  - start pulsed during busy -> ignored, same 240-cycle run.
  - start held high -> second run begins on the cycle done=1.
  - rst_n=0 during stage 2 -> no wr_en afterwards; a fresh start gives a full 240-cycle run.
- FFT_SEQ_SINGLE_STEP_EN defined, step_mode=1 -> FSM stops after each WR; each step pulse yields exactly one wr_en; done after 80 steps.
